// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions.
// - XLEN                : datapath and address width
// - mem_funct3_t        : load/store funct3 encodings (store names alias the load ones)
// - mem_state_t         : MEM-stage memory handshake FSM states
// - mem_size_t          : decoded access width
// - access_size()       : funct3 -> access width, illegal encodings fold to a word access
// - load_is_unsigned()  : funct3 selects zero extension
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd4,
        LHU = 3'd5
    } mem_funct3_t;

    // Stores share the byte/half/word encodings with loads.
    localparam mem_funct3_t SB = LB;
    localparam mem_funct3_t SH = LH;
    localparam mem_funct3_t SW = LW;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    // Anything that is not a legal encoding for the access kind becomes a word.
    function automatic mem_size_t access_size(input logic [2:0] f3, input logic is_store);
        mem_size_t sz;
        sz = SZ_WORD;
        case (f3)
            LB:      sz = SZ_BYTE;
            LH:      sz = SZ_HALF;
            LBU:     sz = is_store ? SZ_WORD : SZ_BYTE;
            LHU:     sz = is_store ? SZ_WORD : SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic load_is_unsigned(input logic [2:0] f3);
        return (f3 == LBU) || (f3 == LHU);
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane steering for the data-memory port.
// Ports:
// - addr_lo    : effective address bits [1:0]
// - funct3     : access size/sign encoding
// - is_store   : 1 = store, 0 = load (selects which encodings are legal)
// - store_data : register data to store
// - rdata      : raw word read from memory
// - be         : byte enables for the access
// - lane_data  : store data replicated across the byte lanes
// - load_data  : read data shifted down and sign/zero extended
// - misaligned : access is not naturally aligned for its size
module load_store_align
    import riscv_pkg::*;
(
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    input  logic            is_store,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] lane_data,
    output logic [XLEN-1:0] load_data,
    output logic            misaligned
);

    mem_size_t       size;
    logic            uns;
    logic [XLEN-1:0] shifted;

    // Size decode, lane steering and load extension.
    always_comb begin
        size       = access_size(funct3, is_store);
        uns        = load_is_unsigned(funct3);
        // Bring the addressed byte/half down to bit 0.
        shifted    = rdata >> {addr_lo, 3'b000};
        be         = 4'b1111;
        lane_data  = store_data;
        load_data  = shifted;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                be         = 4'b0001 << addr_lo;
                lane_data  = {4{store_data[7:0]}};
                load_data  = uns ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                 : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
                misaligned = 1'b0;
            end
            SZ_HALF: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_data  = {2{store_data[15:0]}};
                load_data  = uns ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                 : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
                misaligned = addr_lo[0];
            end
            default: begin
                be         = 4'b1111;
                lane_data  = store_data;
                load_data  = shifted;
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory req/ack FSM, load
// alignment, MEM/WB register and the MEM-stage forwarding tap.
// Ports:
// - clk, rst                 : clock, synchronous active-high reset
// - ex_*                     : instruction arriving from EX
// - dmem_req/we/addr/wdata/be: data-memory request, held until dmem_ack
// - dmem_ack, dmem_rdata     : access completion and raw read word
// - mem_stall                : freeze upstream while the access is outstanding
// - mem_reg_write/rd/forward_value : forwarding tap back to EX
// - misaligned_exc           : misaligned ld/st in this stage
// - wb_*                     : MEM/WB register towards writeback
module mem_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_mem_write_data,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [2:0]      ex_funct3,
    input  logic            ex_reg_write,
    input  logic [4:0]      ex_rd,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            mem_stall,
    output logic            mem_reg_write,
    output logic [4:0]      mem_rd,
    output logic [XLEN-1:0] mem_forward_value,
    output logic            misaligned_exc,
    output logic            wb_valid,
    output logic            wb_reg_write,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data
);

    // EX/MEM register
    logic            exm_valid;
    logic [XLEN-1:0] exm_alu;
    logic [XLEN-1:0] exm_wdata;
    logic            exm_mem_read;
    logic            exm_mem_write;
    logic [2:0]      exm_funct3;
    logic            exm_reg_write;
    logic [4:0]      exm_rd;

    mem_state_t      state;

    logic            mem_op;
    logic            misaligned;
    logic            aligned_op;
    logic [3:0]      be;
    logic [XLEN-1:0] lane_data;
    logic [XLEN-1:0] load_data;

    load_store_align u_align (
        .addr_lo    (exm_alu[1:0]),
        .funct3     (exm_funct3),
        .is_store   (exm_mem_write),
        .store_data (exm_wdata),
        .rdata      (dmem_rdata),
        .be         (be),
        .lane_data  (lane_data),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    assign mem_op     = exm_valid & (exm_mem_read | exm_mem_write);
    assign aligned_op = mem_op & ~misaligned;

    // EX/MEM holds while stalled, so in BUSY aligned_op is still set; the
    // state term keeps the request up regardless.
    assign dmem_req   = aligned_op | (state == BUSY);
    assign dmem_we    = exm_mem_write;
    assign dmem_addr  = {exm_alu[XLEN-1:2], 2'b00};
    assign dmem_wdata = lane_data;
    assign dmem_be    = be;
    assign mem_stall  = dmem_req & ~dmem_ack;

    assign misaligned_exc    = mem_op & misaligned;
    // Load results are not available here; the ID hazard unit covers load-use.
    assign mem_reg_write     = exm_valid & exm_reg_write & ~exm_mem_read;
    assign mem_rd            = exm_rd;
    assign mem_forward_value = exm_alu;

    // EX/MEM pipeline register, frozen during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            exm_valid     <= 1'b0;
            exm_alu       <= '0;
            exm_wdata     <= '0;
            exm_mem_read  <= 1'b0;
            exm_mem_write <= 1'b0;
            exm_funct3    <= 3'd0;
            exm_reg_write <= 1'b0;
            exm_rd        <= 5'd0;
        end else if (!mem_stall) begin
            exm_valid     <= ex_valid;
            exm_alu       <= ex_alu_result;
            exm_wdata     <= ex_mem_write_data;
            exm_mem_read  <= ex_mem_read;
            exm_mem_write <= ex_mem_write;
            exm_funct3    <= ex_funct3;
            exm_reg_write <= ex_reg_write;
            exm_rd        <= ex_rd;
        end else begin
            exm_valid     <= exm_valid;
        end
    end

    // Memory handshake FSM: a same-cycle ack never leaves IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= (aligned_op && !dmem_ack) ? BUSY : IDLE;
                BUSY:    state <= dmem_ack ? IDLE : BUSY;
                default: state <= IDLE;
            endcase
        end
    end

    // MEM/WB pipeline register; a stalled cycle retires a bubble.
    always_ff @(posedge clk) begin
        if (rst || mem_stall) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= '0;
        end else begin
            wb_valid     <= exm_valid & ~(mem_op & misaligned);
            wb_reg_write <= exm_valid & exm_reg_write & ~exm_mem_write
                            & ~(mem_op & misaligned) & (exm_rd != 5'd0);
            wb_rd        <= exm_rd;
            wb_data      <= exm_mem_read ? load_data : exm_alu;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_mem_write_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic        ex_reg_write;
    logic [4:0]  ex_rd;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic [31:0] mem_forward_value;
    logic        misaligned_exc;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int vectors = 0;
    int errors  = 0;

    mem_stage dut (
        .clk               (clk),
        .rst               (rst),
        .ex_valid          (ex_valid),
        .ex_alu_result     (ex_alu_result),
        .ex_mem_write_data (ex_mem_write_data),
        .ex_mem_read       (ex_mem_read),
        .ex_mem_write      (ex_mem_write),
        .ex_funct3         (ex_funct3),
        .ex_reg_write      (ex_reg_write),
        .ex_rd             (ex_rd),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_be           (dmem_be),
        .dmem_ack          (dmem_ack),
        .dmem_rdata        (dmem_rdata),
        .mem_stall         (mem_stall),
        .mem_reg_write     (mem_reg_write),
        .mem_rd            (mem_rd),
        .mem_forward_value (mem_forward_value),
        .misaligned_exc    (misaligned_exc),
        .wb_valid          (wb_valid),
        .wb_reg_write      (wb_reg_write),
        .wb_rd             (wb_rd),
        .wb_data           (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                            input logic rd_op, input logic wr_op, input logic [2:0] f3,
                            input logic rw, input logic [4:0] rd);
        ex_valid          = v;
        ex_alu_result     = alu;
        ex_mem_write_data = sd;
        ex_mem_read       = rd_op;
        ex_mem_write      = wr_op;
        ex_funct3         = f3;
        ex_reg_write      = rw;
        ex_rd             = rd;
    endtask

    task automatic bubble();
        drive_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bubble();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        vectors++;
        if ({dmem_req, mem_stall, misaligned_exc, mem_reg_write, wb_valid, wb_reg_write} !== 6'b0 ||
            wb_rd !== 5'd0 || wb_data !== 32'h0 || mem_rd !== 5'd0 || mem_forward_value !== 32'h0) begin
            errors++;
            $display("FAIL reset: req=%b stall=%b exc=%b mrw=%b wbv=%b wbrw=%b wbrd=%0d wbdata=%h (all required 0)",
                     dmem_req, mem_stall, misaligned_exc, mem_reg_write, wb_valid, wb_reg_write, wb_rd, wb_data);
        end
    endtask

    task automatic test_alu();
        drive_ex(1'b1, 32'h0000_1234, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1, 5'd5);
        tick();
        bubble();
        vectors++;
        if (dmem_req !== 1'b0 || mem_reg_write !== 1'b1 || mem_rd !== 5'd5 || mem_forward_value !== 32'h1234) begin
            errors++;
            $display("FAIL alu_tap: req=%b mrw=%b mrd=%0d fwd=%h, required 0 1 5 00001234",
                     dmem_req, mem_reg_write, mem_rd, mem_forward_value);
        end
        tick();
        vectors++;
        if (wb_valid !== 1'b1 || wb_reg_write !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'h1234) begin
            errors++;
            $display("FAIL alu_wb: v=%b rw=%b rd=%0d data=%h, required 1 1 5 00001234",
                     wb_valid, wb_reg_write, wb_rd, wb_data);
        end
    endtask

    task automatic test_lb_zero_wait();
        drive_ex(1'b1, 32'h0000_0103, 32'h0, 1'b1, 1'b0, 3'd0, 1'b1, 5'd7);
        tick();
        bubble();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h80FF_FF00;
        #1;
        vectors++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h100 || mem_stall !== 1'b0 || mem_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL lb_req: req=%b we=%b addr=%h stall=%b mrw=%b, required 1 0 00000100 0 0",
                     dmem_req, dmem_we, dmem_addr, mem_stall, mem_reg_write);
        end
        tick();
        dmem_ack = 1'b0;
        vectors++;
        if (wb_data !== 32'hFFFF_FF80 || wb_reg_write !== 1'b1 || wb_rd !== 5'd7 || mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL lb_wb: data=%h rw=%b rd=%0d stall=%b, required ffffff80 1 7 0",
                     wb_data, wb_reg_write, wb_rd, mem_stall);
        end
    endtask

    task automatic test_lhu_wait3();
        int stalls = 0;
        int wbv_during = 0;
        logic done = 1'b0;
        drive_ex(1'b1, 32'h0000_0102, 32'h0, 1'b1, 1'b0, 3'd5, 1'b1, 5'd8);
        tick();
        bubble();
        dmem_rdata = 32'hBEEF_0000;
        for (int i = 0; i < 10 && !done; i++) begin
            dmem_ack = (i == 3);
            #1;
            if (mem_stall === 1'b1) stalls++;
            if (dmem_ack) done = 1'b1;
            tick();
            if (!done && wb_valid !== 1'b0) wbv_during++;
        end
        dmem_ack = 1'b0;
        vectors++;
        if (stalls != 3) begin
            errors++;
            $display("FAIL lhu_stall_count: got %0d stall cycles, required 3", stalls);
        end
        vectors++;
        if (wbv_during != 0) begin
            errors++;
            $display("FAIL lhu_wb_bubble: wb_valid high %0d times during stall, required 0", wbv_during);
        end
        vectors++;
        if (wb_data !== 32'h0000_BEEF || wb_valid !== 1'b1 || wb_reg_write !== 1'b1 || wb_rd !== 5'd8) begin
            errors++;
            $display("FAIL lhu_wb: data=%h v=%b rw=%b rd=%0d, required 0000beef 1 1 8",
                     wb_data, wb_valid, wb_reg_write, wb_rd);
        end
        vectors++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL lhu_release: req=%b stall=%b, required 0 0", dmem_req, mem_stall);
        end
    endtask

    task automatic test_store(input string name, input logic [31:0] addr, input logic [31:0] sd,
                              input logic [2:0] f3, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_addr);
        drive_ex(1'b1, addr, sd, 1'b0, 1'b1, f3, 1'b0, 5'd0);
        tick();
        bubble();
        dmem_ack = 1'b1;
        #1;
        vectors++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== exp_be ||
            dmem_wdata !== exp_wdata || dmem_addr !== exp_addr) begin
            errors++;
            $display("FAIL %s: req=%b we=%b be=%b wdata=%h addr=%h, required 1 1 %b %h %h",
                     name, dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr, exp_be, exp_wdata, exp_addr);
        end
        tick();
        dmem_ack = 1'b0;
        vectors++;
        if (wb_reg_write !== 1'b0 || wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_wb: rw=%b v=%b, required 0 1", name, wb_reg_write, wb_valid);
        end
    endtask

    task automatic test_lh_sign();
        drive_ex(1'b1, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 3'd1, 1'b1, 5'd10);
        tick();
        bubble();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1234_8001;
        tick();
        dmem_ack = 1'b0;
        vectors++;
        if (wb_data !== 32'hFFFF_8001 || wb_rd !== 5'd10) begin
            errors++;
            $display("FAIL lh_sign: data=%h rd=%0d, required ffff8001 10", wb_data, wb_rd);
        end
    endtask

    task automatic test_misaligned();
        drive_ex(1'b1, 32'h0000_0102, 32'h0, 1'b1, 1'b0, 3'd2, 1'b1, 5'd9);
        tick();
        bubble();
        #1;
        vectors++;
        if (dmem_req !== 1'b0 || misaligned_exc !== 1'b1 || mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL lw_misaligned: req=%b exc=%b stall=%b, required 0 1 0", dmem_req, misaligned_exc, mem_stall);
        end
        tick();
        vectors++;
        if (misaligned_exc !== 1'b0 || wb_reg_write !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL lw_misaligned_wb: exc=%b rw=%b v=%b, required 0 0 0", misaligned_exc, wb_reg_write, wb_valid);
        end
    endtask

    task automatic test_back_to_back();
        // Two ALU ops in consecutive cycles; the second targets x0.
        drive_ex(1'b1, 32'hAAAA_0001, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1, 5'd3);
        tick();
        drive_ex(1'b1, 32'h5555_0002, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1, 5'd0);
        tick();
        bubble();
        vectors++;
        if (wb_reg_write !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'hAAAA_0001 || mem_forward_value !== 32'h5555_0002) begin
            errors++;
            $display("FAIL b2b_first: rw=%b rd=%0d data=%h fwd=%h, required 1 3 aaaa0001 55550002",
                     wb_reg_write, wb_rd, wb_data, mem_forward_value);
        end
        tick();
        vectors++;
        if (wb_reg_write !== 1'b0 || wb_valid !== 1'b1 || wb_data !== 32'h5555_0002) begin
            errors++;
            $display("FAIL b2b_x0: rw=%b v=%b data=%h, required 0 1 55550002", wb_reg_write, wb_valid, wb_data);
        end
    endtask

    task automatic test_reset_busy();
        drive_ex(1'b1, 32'h0000_0300, 32'h1234_5678, 1'b0, 1'b1, 3'd2, 1'b0, 5'd0);
        tick();
        bubble();
        dmem_ack = 1'b0;
        #1;
        vectors++;
        if (dmem_req !== 1'b1 || mem_stall !== 1'b1 || dmem_be !== 4'b1111 || dmem_wdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL sw_busy: req=%b stall=%b be=%b wdata=%h, required 1 1 1111 12345678",
                     dmem_req, mem_stall, dmem_be, dmem_wdata);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || wb_valid !== 1'b0 || wb_reg_write !== 1'b0 ||
            wb_rd !== 5'd0 || wb_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_busy: req=%b stall=%b wbv=%b wbrw=%b wbrd=%0d wbdata=%h, required all 0",
                     dmem_req, mem_stall, wb_valid, wb_reg_write, wb_rd, wb_data);
        end
        tick();
        vectors++;
        if (dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy_idle: req=%b, required 0", dmem_req);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lb_zero_wait();
        test_lhu_wait3();
        test_store("sb", 32'h0000_0201, 32'h0000_00AB, 3'd0, 4'b0010, 32'hABAB_ABAB, 32'h0000_0200);
        test_store("sh", 32'h0000_0022, 32'h0000_CDEF, 3'd1, 4'b1100, 32'hCDEF_CDEF, 32'h0000_0020);
        test_lh_sign();
        test_misaligned();
        test_back_to_back();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
